// File: rtl/burst_xfer_ctrl_if.sv
// Client/bus handshake bundle for burst_xfer_ctrl; bus_par exists only when PARITY_EN is defined.
interface burst_xfer_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              gnt_0;
    logic              gnt_1;
    logic [LEN_W-1:0]  len_0;
    logic [LEN_W-1:0]  len_1;
    logic [DATA_W-1:0] data_0;
    logic [DATA_W-1:0] data_1;
    logic              valid_0;
    logic              valid_1;
    logic              ready_0;
    logic              ready_1;
    logic [DATA_W-1:0] bus_data;
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_src;
    logic              done_0;
    logic              done_1;
    logic              err;
`ifdef PARITY_EN
    logic              bus_par;
`endif

    modport master (
`ifdef PARITY_EN
        output bus_par,
`endif
        input  gnt_0, gnt_1, len_0, len_1, data_0, data_1, valid_0, valid_1, bus_ready,
        output ready_0, ready_1, bus_data, bus_valid, bus_src, done_0, done_1, err
    );

    modport slave (
`ifdef PARITY_EN
        input  bus_par,
`endif
        output gnt_0, gnt_1, len_0, len_1, data_0, data_1, valid_0, valid_1, bus_ready,
        input  ready_0, ready_1, bus_data, bus_valid, bus_src, done_0, done_1, err
    );
endinterface

// File: rtl/burst_xfer_ctrl.sv
// Moves one burst from the granted client onto the shared bus, then waits for the grant to drop.
// Optional even parity on bus_data is enabled with the PARITY_EN macro.
module burst_xfer_ctrl #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic          clock,
    input  logic          reset,
    burst_xfer_ctrl_if.master xf
);
    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        XFER0   = 4'b0010,
        XFER1   = 4'b0100,
        RELEASE = 4'b1000
    } state_t;

    state_t            state, state_next;
    logic [LEN_W-1:0]  cnt, cnt_next;
    logic [LEN_W-1:0]  len_q, len_next;
    logic              src_next, done_0_next, done_1_next, err_next;
    logic              sel, gnt_sel, valid_sel, beat;
    logic [DATA_W-1:0] word;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            len_q      <= '0;
            xf.bus_src <= 1'b0;
            xf.done_0  <= 1'b0;
            xf.done_1  <= 1'b0;
            xf.err     <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            len_q      <= len_next;
            xf.bus_src <= src_next;
            xf.done_0  <= done_0_next;
            xf.done_1  <= done_1_next;
            xf.err     <= err_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        len_next    = len_q;
        src_next    = xf.bus_src;
        done_0_next = 1'b0;
        done_1_next = 1'b0;
        err_next    = 1'b0;
        xf.bus_data  = '0;
        xf.bus_valid = 1'b0;
        xf.ready_0   = 1'b0;
        xf.ready_1   = 1'b0;
        sel       = (state == XFER1);
        gnt_sel   = sel ? xf.gnt_1   : xf.gnt_0;
        valid_sel = sel ? xf.valid_1 : xf.valid_0;
        word      = sel ? xf.data_1  : xf.data_0;
        beat      = 1'b0;

        unique case (state)
            IDLE: begin
                if (xf.gnt_0 && xf.gnt_1) begin
                    err_next = 1'b1;
                end else if (xf.gnt_0) begin
                    state_next = XFER0;
                    len_next   = xf.len_0;
                    cnt_next   = '0;
                    src_next   = 1'b0;
                end else if (xf.gnt_1) begin
                    state_next = XFER1;
                    len_next   = xf.len_1;
                    cnt_next   = '0;
                    src_next   = 1'b1;
                end
            end
            XFER0, XFER1: begin
                xf.bus_data  = word;
                xf.bus_valid = valid_sel;
                xf.ready_0   = !sel && xf.bus_ready;
                xf.ready_1   = sel && xf.bus_ready;
                beat         = valid_sel && xf.bus_ready;
                // Losing the grant mid-burst wins over any beat completing in the same cycle.
                if (!gnt_sel) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (beat) begin
                    if (cnt == len_q) begin
                        done_0_next = !sel;
                        done_1_next = sel;
                        state_next  = RELEASE;
                        cnt_next    = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            RELEASE: begin
                if (!xf.gnt_0 && !xf.gnt_1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef PARITY_EN
    assign xf.bus_par = ^xf.bus_data;
`endif
endmodule

// File: tb/tb_burst_xfer_ctrl.sv
// Randomized self-checking bench for burst_xfer_ctrl; expectations come from burst-level bookkeeping.
module tb_burst_xfer_ctrl;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic last_src = 1'b0;

    always #5 clock = ~clock;

    burst_xfer_ctrl_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) xf ();

    burst_xfer_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clock (clock),
        .reset (reset),
        .xf    (xf.master)
    );

    function automatic logic [6:0] obs();
        return {xf.bus_valid, xf.ready_0, xf.ready_1, xf.done_0, xf.done_1, xf.err, xf.bus_src};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        xf.gnt_0 = 1'b0; xf.gnt_1 = 1'b0;
        xf.len_0 = '0;   xf.len_1 = '0;
        xf.data_0 = '0;  xf.data_1 = '0;
        xf.valid_0 = 1'b0; xf.valid_1 = 1'b0;
        xf.bus_ready = 1'b0;
    endtask

    task automatic drive_client(input int c, input logic v, input logic [DATA_W-1:0] d);
        if (c == 0) begin
            xf.valid_0 = v; xf.data_0 = d;
            xf.valid_1 = 1'($urandom_range(0, 1)); xf.data_1 = DATA_W'($urandom);
        end else begin
            xf.valid_1 = v; xf.data_1 = d;
            xf.valid_0 = 1'($urandom_range(0, 1)); xf.data_0 = DATA_W'($urandom);
        end
        xf.len_0 = LEN_W'($urandom);
        xf.len_1 = LEN_W'($urandom);
    endtask

    // One complete grant cycle: burst of len+1 accepted beats, done pulse, hold, release.
    // mode 0: valid/ready always high; 1: valid high, ready toggling 0/1; 2: both random.
    task automatic do_burst(input int c, input int len, input int mode, input int hold, input string tag);
        int beats = 0;
        int cyc = 0;
        logic v, r;
        logic [DATA_W-1:0] d;
        logic [6:0] exp;
        xf.gnt_0 = (c == 0); xf.gnt_1 = (c == 1);
        if (c == 0) xf.len_0 = LEN_W'(len); else xf.len_1 = LEN_W'(len);
        tick();
        last_src = c[0];
        while (beats < len + 1 && cyc < 200) begin
            v = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            r = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            d = DATA_W'($urandom);
            drive_client(c, v, d);
            xf.bus_ready = r;
            if (mode == 2) begin
                if (c == 0) xf.gnt_1 = 1'($urandom_range(0, 1)); else xf.gnt_0 = 1'($urandom_range(0, 1));
            end
            #1;
            exp = {v, (c == 0) && r, (c == 1) && r, 1'b0, 1'b0, 1'b0, c[0]};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL %s beat%0d ctl got %b exp %b", tag, beats, obs(), exp);
            end
            checks++;
            if (xf.bus_data !== d) begin
                errors++;
                $display("FAIL %s beat%0d data got %h exp %h", tag, beats, xf.bus_data, d);
            end
            if (v && r) beats++;
            cyc++;
            tick();
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL %s timeout beats got %0d exp %0d", tag, beats, len + 1);
        end
        xf.gnt_0 = (c == 0); xf.gnt_1 = (c == 1);
        drive_client(c, 1'b1, DATA_W'($urandom));
        xf.bus_ready = 1'b1;
        #1;
        exp = {3'b000, c == 0, c == 1, 1'b0, c[0]};
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL %s done ctl got %b exp %b", tag, obs(), exp);
        end
        for (int i = 0; i < hold; i++) begin
            xf.gnt_0 = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            xf.gnt_1 = (c == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            #1;
            exp = {6'b0, c[0]};
            checks++;
            if (obs() !== exp || xf.bus_data !== '0) begin
                errors++;
                $display("FAIL %s hold%0d ctl got %b exp %b data %h", tag, i, obs(), exp, xf.bus_data);
            end
        end
        xf.gnt_0 = 1'b0; xf.gnt_1 = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (obs() !== {6'b0, c[0]}) begin
            errors++;
            $display("FAIL %s idle ctl got %b exp %b", tag, obs(), {6'b0, c[0]});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        xf.gnt_0 = 1'b1; xf.valid_0 = 1'b1; xf.bus_ready = 1'b1; xf.data_0 = 8'hA5;
        tick(); tick();
        checks++;
        if (obs() !== 7'b0 || xf.bus_data !== '0) begin
            errors++;
            $display("FAIL reset ctl got %b exp %b data %h", obs(), 7'b0, xf.bus_data);
        end
        idle_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_burst0();
        do_burst(0, 3, 0, 2, "burst0");
    endtask

    task automatic test_stall1();
        do_burst(1, 0, 1, 1, "stall1");
    endtask

    task automatic test_both_err();
        xf.gnt_0 = 1'b1; xf.gnt_1 = 1'b1;
        xf.valid_0 = 1'b1; xf.valid_1 = 1'b1; xf.bus_ready = 1'b1;
        tick();
        xf.gnt_0 = 1'b0; xf.gnt_1 = 1'b0;
        #1;
        checks++;
        if (obs() !== {5'b0, 1'b1, last_src}) begin
            errors++;
            $display("FAIL both_err pulse got %b exp %b", obs(), {5'b0, 1'b1, last_src});
        end
        tick();
        checks++;
        if (obs() !== {6'b0, last_src}) begin
            errors++;
            $display("FAIL both_err clear got %b exp %b", obs(), {6'b0, last_src});
        end
    endtask

    task automatic test_abort();
        xf.gnt_0 = 1'b1; xf.gnt_1 = 1'b0; xf.len_0 = 4'd4;
        xf.valid_0 = 1'b1; xf.bus_ready = 1'b1;
        tick();
        last_src = 1'b0;
        tick(); tick();
        xf.gnt_0 = 1'b0;
        tick();
        checks++;
        if (obs() !== {5'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL abort pulse got %b exp %b", obs(), 7'b0000010);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs() !== 7'b0) begin
                errors++;
                $display("FAIL abort after%0d got %b exp %b", i, obs(), 7'b0);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        xf.gnt_1 = 1'b1; xf.gnt_0 = 1'b0; xf.len_1 = 4'd5;
        xf.valid_1 = 1'b1; xf.bus_ready = 1'b1;
        tick();
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if (obs() !== 7'b0 || xf.bus_data !== '0) begin
            errors++;
            $display("FAIL reset_mid got %b exp %b data %h", obs(), 7'b0, xf.bus_data);
        end
        reset = 1'b0;
        do_burst(1, 5, 0, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 14; n++)
            do_burst($urandom_range(0, 1), $urandom_range(0, 15), 2, $urandom_range(0, 2), "random");
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        logic [DATA_W-1:0] words [4] = '{8'h00, 8'h01, 8'hFF, 8'h7F};
        logic              par   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        xf.gnt_0 = 1'b1; xf.gnt_1 = 1'b0; xf.len_0 = 4'd3;
        xf.valid_0 = 1'b1; xf.bus_ready = 1'b1;
        #1;
        checks++;
        if (xf.bus_par !== 1'b0) begin
            errors++;
            $display("FAIL parity idle got %b exp 0", xf.bus_par);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            xf.data_0 = words[i];
            #1;
            checks++;
            if (xf.bus_par !== par[i]) begin
                errors++;
                $display("FAIL parity word%0d got %b exp %b", i, xf.bus_par, par[i]);
            end
            tick();
        end
        last_src = 1'b0;
        xf.gnt_0 = 1'b0;
        tick(); tick();
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_burst0();
        test_stall1();
        test_both_err();
        test_abort();
        test_reset_mid();
        test_random();
`ifdef PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
